// File: rtl/lcd_pkg.sv
`default_nettype none
// ============================================================================
// lcd_pkg : shared constants, state encoding and DDRAM address mapping for the
//           HD44780 frame scheduler.
// Revision: 1.0
// ============================================================================
package lcd_pkg;

   localparam logic [7:0] LCD_LINE1_BASE = 8'h80;
   localparam logic [7:0] LCD_LINE2_BASE = 8'hC0;
   localparam logic [7:0] LCD_BLANK      = 8'h20;
   localparam int         LCD_COLS       = 16;
   localparam int         LCD_POS_W      = 5;
   localparam int         LCD_POSITIONS  = 2 * LCD_COLS;

   typedef enum logic [0:0] {
      INIT = 1'b0,
      RUN  = 1'b1
   } lcd_state_e;

   // Bit 4 of the position selects the line; the low nibble is the column.
   function automatic logic [7:0] lcd_pos_to_addr(input logic [LCD_POS_W-1:0] pos);
      if (!pos[LCD_POS_W-1]) begin
         return LCD_LINE1_BASE + {4'b0000, pos[3:0]};
      end else begin
         return LCD_LINE2_BASE + {4'b0000, pos[3:0]};
      end
   endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_dirty_pick.sv
`default_nettype none
// ============================================================================
// lcd_dirty_pick : lowest-set-bit encoder over the 32-entry dirty bitmap.
// Revision: 1.0
// ============================================================================
module lcd_dirty_pick
   import lcd_pkg::*;
(
   input  logic [LCD_POSITIONS-1:0] dirty_i,
   output logic [LCD_POS_W-1:0]     idx_o,
   output logic                     valid_o
);

   // Scanning downwards lets the lowest set index overwrite any higher one.
   always_comb begin
      idx_o   = '0;
      valid_o = 1'b0;
      for (int i = LCD_POSITIONS - 1; i >= 0; i--) begin
         if (dirty_i[i]) begin
            idx_o   = LCD_POS_W'(i);
            valid_o = 1'b1;
         end
      end
   end

endmodule
`default_nettype wire

// File: rtl/lcd_frame_scheduler.sv
`default_nettype none
// ============================================================================
// lcd_frame_scheduler : 2x16 frame buffer with dirty-first round-robin refresh
//                       feeding address/character pairs to the HD44780 driver.
// Revision: 1.0
// ============================================================================
module lcd_frame_scheduler
   import lcd_pkg::*;
#(
   parameter int unsigned INIT_CYCLES = 16,
   parameter int unsigned SLOT_CYCLES = 4,
   parameter logic [7:0]  BLANK       = LCD_BLANK
) (
   input  logic                 CLK_400Hz,
   input  logic                 reset,
   input  logic                 wr_en,
   input  logic [LCD_POS_W-1:0] wr_pos,
   input  logic [7:0]           wr_char,
   input  logic                 clr_req,
   output logic [7:0]           addressIN,
   output logic [7:0]           characterIN,
   output logic                 slot_start,
   output logic [LCD_POS_W-1:0] slot_pos,
   output logic                 dirty_any
);

   localparam int unsigned CNT_MAX = (INIT_CYCLES > SLOT_CYCLES) ? INIT_CYCLES : SLOT_CYCLES;
   localparam int          CNT_W   = $clog2(CNT_MAX + 1);
   localparam logic [CNT_W-1:0] INIT_LAST = CNT_W'(INIT_CYCLES - 1);
   localparam logic [CNT_W-1:0] SLOT_LAST = CNT_W'(SLOT_CYCLES - 1);

   lcd_state_e             state_q, state_d;
   logic [CNT_W-1:0]       cnt_q, cnt_d;
   logic                   load;

   logic [7:0]             frame_q [LCD_POSITIONS];
   logic [7:0]             frame_d [LCD_POSITIONS];
   logic [LCD_POSITIONS-1:0] dirty_q, dirty_d;
   logic [LCD_POS_W-1:0]   rr_ptr_q, rr_ptr_d;

   logic [7:0]             addr_q, addr_d;
   logic [7:0]             char_q, char_d;
   logic [LCD_POS_W-1:0]   pos_q, pos_d;
   logic                   slot_start_q, slot_start_d;
   logic                   dirty_any_q, dirty_any_d;

   logic [LCD_POS_W-1:0]   pick_idx;
   logic                   pick_valid;
   logic [LCD_POS_W-1:0]   sel;

   lcd_dirty_pick u_dirty_pick (
      .dirty_i (dirty_q),
      .idx_o   (pick_idx),
      .valid_o (pick_valid)
   );

   always_ff @(posedge CLK_400Hz or posedge reset) begin
      if (reset) begin
         state_q <= INIT;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         INIT:    if (cnt_q == INIT_LAST) state_d = RUN;
         RUN:     state_d = RUN;
         default: state_d = INIT;
      endcase
   end

   // The counter serves as init timer in INIT and slot phase in RUN.
   always_comb begin
      load  = 1'b0;
      cnt_d = cnt_q + CNT_W'(1);
      case (state_q)
         INIT: begin
            if (cnt_q == INIT_LAST) begin
               load  = 1'b1;
               cnt_d = '0;
            end
         end
         RUN: begin
            if (cnt_q == SLOT_LAST) begin
               load  = 1'b1;
               cnt_d = '0;
            end
         end
         default: cnt_d = '0;
      endcase
   end

   assign sel = pick_valid ? pick_idx : rr_ptr_q;

   // Ordering: the load retires its dirty bit, a clear then re-marks everything,
   // and a host write lands last so it always survives.
   always_comb begin
      frame_d      = frame_q;
      dirty_d      = dirty_q;
      rr_ptr_d     = rr_ptr_q;
      addr_d       = addr_q;
      char_d       = char_q;
      pos_d        = pos_q;
      slot_start_d = load;

      if (load) begin
         if (pick_valid) begin
            dirty_d[pick_idx] = 1'b0;
         end else begin
            rr_ptr_d = rr_ptr_q + LCD_POS_W'(1);
         end
         addr_d = lcd_pos_to_addr(sel);
         char_d = frame_q[sel];
         pos_d  = sel;
      end

      if (clr_req) begin
         for (int i = 0; i < LCD_POSITIONS; i++) begin
            frame_d[i] = BLANK;
         end
         dirty_d = '1;
      end

      if (wr_en) begin
         frame_d[wr_pos] = wr_char;
         dirty_d[wr_pos] = 1'b1;
      end

      dirty_any_d = |dirty_d;
   end

   always_ff @(posedge CLK_400Hz or posedge reset) begin
      if (reset) begin
         cnt_q        <= '0;
         for (int i = 0; i < LCD_POSITIONS; i++) begin
            frame_q[i] <= BLANK;
         end
         dirty_q      <= '0;
         rr_ptr_q     <= '0;
         addr_q       <= LCD_LINE1_BASE;
         char_q       <= BLANK;
         pos_q        <= '0;
         slot_start_q <= 1'b0;
         dirty_any_q  <= 1'b0;
      end else begin
         cnt_q        <= cnt_d;
         frame_q      <= frame_d;
         dirty_q      <= dirty_d;
         rr_ptr_q     <= rr_ptr_d;
         addr_q       <= addr_d;
         char_q       <= char_d;
         pos_q        <= pos_d;
         slot_start_q <= slot_start_d;
         dirty_any_q  <= dirty_any_d;
      end
   end

   assign addressIN   = addr_q;
   assign characterIN = char_q;
   assign slot_pos    = pos_q;
   assign slot_start  = slot_start_q;
   assign dirty_any   = dirty_any_q;

endmodule
`default_nettype wire

// File: tb/tb_lcd_frame_scheduler.sv
`default_nettype none
// ============================================================================
// tb_lcd_frame_scheduler : scoreboard bench for the LCD frame scheduler.
// Revision: 1.0
// ============================================================================
module tb_lcd_frame_scheduler;

   logic       clk     = 1'b0;
   logic       reset   = 1'b1;
   logic       wr_en   = 1'b0;
   logic [4:0] wr_pos  = '0;
   logic [7:0] wr_char = '0;
   logic       clr_req = 1'b0;
   logic [7:0] addressIN;
   logic [7:0] characterIN;
   logic       slot_start;
   logic [4:0] slot_pos;
   logic       dirty_any;

   lcd_frame_scheduler dut (
      .CLK_400Hz   (clk),
      .reset       (reset),
      .wr_en       (wr_en),
      .wr_pos      (wr_pos),
      .wr_char     (wr_char),
      .clr_req     (clr_req),
      .addressIN   (addressIN),
      .characterIN (characterIN),
      .slot_start  (slot_start),
      .slot_pos    (slot_pos),
      .dirty_any   (dirty_any)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic [7:0] a;
      logic [7:0] c;
      logic [4:0] p;
   } slot_t;

   int          n_assert = 0;
   int          n_fail   = 0;
   int          edge_cnt = 0;
   logic [7:0]  m_buf [32];
   logic [31:0] m_dirty;
   logic [4:0]  m_rr;
   slot_t       exp_q [$];
   slot_t       cur;

   function automatic logic [7:0] addr_of(input logic [4:0] p);
      if (p < 5'd16) return 8'h80 + {3'b000, p};
      else           return 8'hC0 + ({3'b000, p} - 8'd16);
   endfunction

   function automatic logic [4:0] pred_sel();
      if (m_dirty != 0) begin
         for (int i = 0; i < 32; i++) if (m_dirty[i]) return 5'(i);
      end
      return m_rr;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
      m_dirty  = '0;
      m_rr     = '0;
      edge_cnt = 0;
      exp_q.delete();
      cur.a = 8'h80;
      cur.c = 8'h20;
      cur.p = 5'd0;
   endtask

   task automatic tick(input bit we, input logic [4:0] p, input logic [7:0] ch, input bit clr);
      bit         ld;
      logic [4:0] s;
      slot_t      e;
      wr_en   = we;
      wr_pos  = p;
      wr_char = ch;
      clr_req = clr;
      @(posedge clk);
      edge_cnt++;
      ld = (edge_cnt >= 16) && (((edge_cnt - 16) % 4) == 0);
      if (ld) begin
         s   = pred_sel();
         e.a = addr_of(s);
         e.c = m_buf[s];
         e.p = s;
         exp_q.push_back(e);
         if (m_dirty != 0) m_dirty[s] = 1'b0;
         else              m_rr = m_rr + 5'd1;
      end
      if (clr) begin
         for (int i = 0; i < 32; i++) m_buf[i] = 8'h20;
         m_dirty = '1;
      end
      if (we) begin
         m_buf[p]   = ch;
         m_dirty[p] = 1'b1;
      end
      #1;
      if (ld) begin
         cur = exp_q.pop_front();
         chk("slot_start_hi", {31'b0, slot_start}, 32'd1);
      end else begin
         chk("slot_start_lo", {31'b0, slot_start}, 32'd0);
      end
      chk("addressIN",   {24'b0, addressIN},   {24'b0, cur.a});
      chk("characterIN", {24'b0, characterIN}, {24'b0, cur.c});
      chk("slot_pos",    {27'b0, slot_pos},    {27'b0, cur.p});
      chk("dirty_any",   {31'b0, dirty_any},   {31'b0, |m_dirty});
      @(negedge clk);
      wr_en   = 1'b0;
      clr_req = 1'b0;
   endtask

   task automatic run_to(input int n);
      while (edge_cnt < n) tick(1'b0, 5'd0, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1;
      #1;
      chk("rst_addr", {24'b0, addressIN},   32'h80);
      chk("rst_char", {24'b0, characterIN}, 32'h20);
      chk("rst_pos",  {27'b0, slot_pos},    32'd0);
      chk("rst_ss",   {31'b0, slot_start},  32'd0);
      chk("rst_dany", {31'b0, dirty_any},   32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
   endtask

   initial begin
      logic [4:0] s;
      model_reset();

      // Idle sweep: 32 positions in order, then wrap to 0.
      do_reset();
      run_to(15);
      chk("init_no_slot", {31'b0, slot_start}, 32'd0);
      run_to(144);
      chk("wrap_pos0", {27'b0, slot_pos}, 32'd0);
      chk("wrap_addr", {24'b0, addressIN}, 32'h80);
      run_to(148);

      // Single write jumps the queue, round-robin resumes afterwards.
      do_reset();
      run_to(29);
      tick(1'b1, 5'd5, 8'h41, 1'b0);
      run_to(32);
      chk("w5_addr", {24'b0, addressIN},   32'h85);
      chk("w5_char", {24'b0, characterIN}, 32'h41);
      run_to(36);
      chk("rr_resume", {27'b0, slot_pos}, 32'd4);

      // Two writes in one slot are served lowest index first.
      tick(1'b1, 5'd20, 8'h42, 1'b0);
      tick(1'b1, 5'd3,  8'h43, 1'b0);
      run_to(40);
      chk("w3_addr", {24'b0, addressIN},   32'h83);
      chk("w3_char", {24'b0, characterIN}, 32'h43);
      run_to(44);
      chk("w20_addr", {24'b0, addressIN},   32'hC4);
      chk("w20_char", {24'b0, characterIN}, 32'h42);

      // HELLO then clear: 32 blank slots in index order.
      tick(1'b1, 5'd0, 8'h48, 1'b0);
      tick(1'b1, 5'd1, 8'h45, 1'b0);
      tick(1'b1, 5'd2, 8'h4C, 1'b0);
      tick(1'b1, 5'd3, 8'h4C, 1'b0);
      tick(1'b1, 5'd4, 8'h4F, 1'b0);
      tick(1'b0, 5'd0, 8'h00, 1'b1);
      for (int k = 0; k < 32; k++) begin
         run_to(52 + 4 * k);
         chk("clr_pos",  {27'b0, slot_pos},    k);
         chk("clr_char", {24'b0, characterIN}, 32'h20);
         if (k == 30) chk("clr_dany_hi", {31'b0, dirty_any}, 32'd1);
         if (k == 31) chk("clr_dany_lo", {31'b0, dirty_any}, 32'd0);
      end

      // Write to the position being loaded on its load edge.
      run_to(179);
      s = pred_sel();
      tick(1'b1, s, 8'h5A, 1'b0);
      chk("same_edge_pos", {27'b0, slot_pos},    {27'b0, s});
      chk("same_edge_old", {24'b0, characterIN}, 32'h20);
      chk("same_edge_dirty", {31'b0, dirty_any}, 32'd1);
      run_to(184);
      chk("same_edge_next_pos",  {27'b0, slot_pos},    {27'b0, s});
      chk("same_edge_next_char", {24'b0, characterIN}, 32'h5A);
      run_to(186);

      // Asynchronous reset in phase 2 of a slot.
      #1;
      reset = 1'b1;
      #1;
      chk("arst_addr", {24'b0, addressIN},   32'h80);
      chk("arst_char", {24'b0, characterIN}, 32'h20);
      chk("arst_pos",  {27'b0, slot_pos},    32'd0);
      chk("arst_ss",   {31'b0, slot_start},  32'd0);
      chk("arst_dany", {31'b0, dirty_any},   32'd0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      model_reset();
      run_to(15);
      chk("arst_no_early_slot", {31'b0, slot_start}, 32'd0);
      run_to(16);
      chk("arst_first_slot", {31'b0, slot_start}, 32'd1);
      run_to(36);
      chk("arst_blank_pos",  {27'b0, slot_pos},    32'd5);
      chk("arst_blank_char", {24'b0, characterIN}, 32'h20);
      run_to(40);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/lcd_frame_scheduler.md
# lcd_frame_scheduler

Sequencer that feeds the 8-bit parallel HD44780 LCD driver FSM with `addressIN`/`characterIN` pairs. It holds a 2×16 character frame buffer written by the host, and refreshes the panel continuously in round-robin order. Recently written positions get priority in the refresh order. The block runs on the same 400 Hz clock as the driver and updates its outputs only on the driver's write-slot boundaries.

## Interface
Parameters:
- `INIT_CYCLES`, default 16: clock edges after reset release before the driver enters its first `write_address` state.
- `SLOT_CYCLES`, default 4: driver clocks per address+character write loop.
- `BLANK`, default 8'h20: fill character.

Ports:
- `CLK_400Hz`, in, 1: clock shared with the LCD driver.
- `reset`, in, 1: asynchronous, active-high. At system level, the driver's `resetn` is its inverse.
- `wr_en`, in, 1: host write strobe, one position per cycle, always accepted.
- `wr_pos`, in, 5: 0–15 is line 1, 16–31 is line 2.
- `wr_char`, in, 8: ASCII code.
- `clr_req`, in, 1: single-cycle pulse that blanks the whole frame.
- `addressIN`, out, 8: DDRAM set-address command to the driver.
- `characterIN`, out, 8: character to the driver.
- `slot_start`, out, 1: high for one cycle in the first cycle of each slot.
- `slot_pos`, out, 5: position currently presented.
- `dirty_any`, out, 1: at least one position is pending priority refresh.

## Operation
- Storage: `buf[0:31]`, 8 bits each, plus a `dirty[31:0]` bitmap and a 5-bit `rr_ptr`.
- Reset state:
  - every `buf` entry is `BLANK`; `dirty` = 0; `rr_ptr` = 0
  - `addressIN` = 8'h80; `characterIN` = `BLANK`
  - `slot_pos` = 0; `slot_start` = 0; `dirty_any` = 0
- Host write: `buf[wr_pos]` ← `wr_char` and `dirty[wr_pos]` ← 1 on the clock edge.
- Clear: `clr_req` sets every `buf` entry to `BLANK` and every `dirty` bit to 1.
- Simultaneous `clr_req` and `wr_en`: the clear is applied first, then the write. The written position holds `wr_char` and is dirty.
- Address mapping: pos p < 16 → 8'h80 + p; p ≥ 16 → 8'hC0 + (p − 16).
- FSM states:
  - `INIT`: counts `INIT_CYCLES` edges; on the final edge it performs the first slot load and goes to `RUN`.
  - `RUN`: a phase counter counts 0 to `SLOT_CYCLES`−1; when it wraps, a slot load is performed.
- Slot load, on the load edge:
  - If `dirty` ≠ 0: select the lowest set index and clear its dirty bit. A `wr_en` to the same index on the same edge keeps the bit set. `rr_ptr` is unchanged.
  - Otherwise: select `rr_ptr`, then `rr_ptr` ← `rr_ptr` + 1 mod 32 (31 wraps to 0).
  - `addressIN`, `characterIN` and `slot_pos` are registered from the selected position. The character is a snapshot of the pre-edge `buf` contents; a same-edge write is picked up on a later slot.
- Outputs are constant for the whole slot, regardless of host activity.

## Timing
- Load edges occur at edge `INIT_CYCLES` + k·`SLOT_CYCLES` after reset release (16, 20, 24, …). These are exactly the edges on which the driver enters `write_address`, so the address stays stable through `write_address`/`toggle_e9` and the character through `write_char`/`toggle_e10`.
- `slot_start` is high in the cycle following each load edge.
- `dirty_any` is registered and reflects the bitmap after the current edge.
- Write-to-panel latency: at most 1 slot plus the number of lower-indexed dirty positions ahead of it.
- A full-frame clear completes in 32 slots (128 clocks).
- Reset asserted mid-slot: all registers return to reset values immediately, the buffer is blanked, and `INIT` restarts the full `INIT_CYCLES` count, in lockstep with the driver's reset.

## Structure
- The shared package `lcd_pkg` holds:
  - `LCD_LINE1_BASE` = 8'h80, `LCD_LINE2_BASE` = 8'hC0, `LCD_BLANK` = 8'h20
  - `LCD_COLS` = 16, `LCD_POS_W` = 5
  - the pos→DDRAM-address function
  - the state encoding `{INIT, RUN}`
- Sub-module `lcd_dirty_pick`: combinational lowest-set-bit encoder, 32 bits in, 5-bit index plus a valid output.

## Test plan
- Reset, no writes:
  - the outputs hold 8'h80/8'h20 until edge 16
  - the slots then present positions 0,1,…,31 with addresses 8'h80…8'h8F, 8'hC0…8'hCF, all 8'h20
  - the position after 31 wraps to 0
- Write pos 5 = 8'h41 at edge 30 → the slot loaded at edge 32 shows 8'h85/8'h41; round-robin then resumes from the position it had reached.
- Writes to pos 20 (8'h42) and pos 3 (8'h43) in the same slot → the next slot shows 8'h83/8'h43, and the one after shows 8'hC4/8'h42.
- `clr_req` after writing "HELLO" → the next 32 slots present all positions in index order, all 8'h20; `dirty_any` falls after the 32nd load.
- A write to the position being selected, on its load edge:
  - the old character is shown
  - the bit stays dirty and the new character appears in the following slot
  - the outputs never change mid-slot
- Reset asserted in phase 2 of a slot → the outputs are 8'h80/8'h20 immediately, the buffer is blank, and the first load occurs 16 edges after release.
